mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_picker2.sv | 18 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding,
// requester index type and a one-hot helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Requester index: 0 = core LSU, 1 = debug/DMA.
  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin picker: on a tie the grant goes to the requester
// that was not granted last; a lone request is granted directly.
module rr_picker2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IDLE grants one requester, BUSY drives the
// downstream bus until bus_ack, RESP returns one completion pulse.
// Build option: MEM_ARB_TIMEOUT_EN adds a BUSY timeout that completes with m_err.
//
// Handshake: m_gnt pulses in the IDLE cycle a request is accepted; the
// requester drops m_req after that. bus_req stays high with stable
// bus_we/addr/wdata until bus_ack is sampled high on a rising edge.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_we,
  input  logic [ADDR_W-1:0] m_addr0,
  input  logic [ADDR_W-1:0] m_addr1,
  input  logic [ADDR_W-1:0] m_wdata0,
  input  logic [ADDR_W-1:0] m_wdata1,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [ADDR_W-1:0] m_rdata,
  output logic              m_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [ADDR_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [ADDR_W-1:0] bus_rdata,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE = ARB_IDLE;
  localparam logic [1:0] S_BUSY = ARB_BUSY;
  localparam logic [1:0] S_RESP = ARB_RESP;

  logic [1:0]        r_state;
  logic              r_last;
  req_idx_t          r_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;
  req_idx_t          w_gidx;
  logic              w_timeout;

  rr_picker2 u_pick (
    .req  (m_req),
    .last (r_last),
    .gnt  (w_pick)
  );

  // Grant is combinational so the request is accepted in the IDLE cycle itself.
  assign w_gnt  = (r_state == S_IDLE && !rst) ? w_pick : 2'b00;
  assign w_gidx = w_pick[1];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != S_BUSY) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_BUSY) && !bus_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No counter: BUSY waits for bus_ack indefinitely.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_idx   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_state <= S_BUSY;
            r_last  <= w_gidx;
            r_idx   <= w_gidx;
            r_we    <= m_we[w_gidx];
            r_addr  <= w_gidx ? m_addr1 : m_addr0;
            r_wdata <= w_gidx ? m_wdata1 : m_wdata0;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            r_state <= S_RESP;
            r_rdata <= r_we ? '0 : bus_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_state <= S_RESP;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_gnt       = w_gnt;
  assign m_rvalid    = (r_state == S_RESP) ? idx_to_onehot(r_idx) : 2'b00;
  assign m_rdata     = r_rdata;
  assign m_err       = (r_state == S_RESP) && r_err;
  assign bus_req     = (r_state == S_BUSY);
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;
  assign o_dbg_state = r_state;

endmodule
